// File: rtl/inst_buf.sv
// inst_buf: circular queue of {inst, pc} entries between fetch and the two decoders.
// Latency: an entry pushed at edge N is presented on dec_* in cycle N+1 (no bypass).
// Backpressure: if_ready drops when fewer than two entries are free; decode pops 0..2 per cycle.
module inst_buf #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        if_valid,
   output logic        if_ready,
   input  logic [31:0] if_pc,
   input  logic [1:0]  if_mask,
   input  logic [31:0] if_inst0,
   input  logic [31:0] if_inst1,
   output logic [1:0]  dec_valid,
   output logic [31:0] dec_inst0,
   output logic [31:0] dec_inst1,
   output logic [31:0] dec_pc0,
   output logic [31:0] dec_pc1,
   input  logic [1:0]  dec_take
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]   mem_inst [DEPTH];
   logic [31:0]   mem_pc   [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic [AW-1:0] wr_ptr_nxt, rd_ptr_nxt;
   logic          push;
   logic [1:0]    pushed, take_req, avail, taken;
   logic [31:0]   pc_hi, wr0_inst, wr0_pc;

   // Decoder-facing outputs depend on registered state only; empty slots show a NOP at pc 0.
   always_comb begin
      if_ready   = (count_q <= CW'(DEPTH - 2));
      dec_valid  = {count_q >= CW'(2), count_q != '0};
      rd_ptr_nxt = rd_ptr_q + AW'(1);
      dec_inst0  = dec_valid[0] ? mem_inst[rd_ptr_q]   : NOP;
      dec_pc0    = dec_valid[0] ? mem_pc[rd_ptr_q]     : 32'h0;
      dec_inst1  = dec_valid[1] ? mem_inst[rd_ptr_nxt] : NOP;
      dec_pc1    = dec_valid[1] ? mem_pc[rd_ptr_nxt]   : 32'h0;
   end

   // Push/pop amounts: holes in the fetch mask are compacted, dec_take is clipped to what is shown.
   always_comb begin
      push       = if_valid && if_ready && !flush;
      pushed     = push ? ({1'b0, if_mask[0]} + {1'b0, if_mask[1]}) : 2'd0;
      take_req   = (dec_take == 2'd3) ? 2'd2 : dec_take;
      avail      = {1'b0, dec_valid[0]} + {1'b0, dec_valid[1]};
      taken      = (take_req < avail) ? take_req : avail;
      pc_hi      = if_pc + 32'd4;
      wr0_inst   = if_mask[0] ? if_inst0 : if_inst1;
      wr0_pc     = if_mask[0] ? if_pc    : pc_hi;
      wr_ptr_nxt = wr_ptr_q + AW'(1);
   end

   // Next pointer/count state; flush discards any same-cycle push or pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         wr_ptr_d = wr_ptr_q + AW'(pushed);
         rd_ptr_d = rd_ptr_q + AW'(taken);
         count_d  = count_q + CW'(pushed) - CW'(taken);
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage (not reset): first valid slot lands at wr_ptr, a second one at wr_ptr+1.
   always_ff @(posedge clk) begin
      if (push && (if_mask != 2'b00)) begin
         mem_inst[wr_ptr_q] <= wr0_inst;
         mem_pc[wr_ptr_q]   <= wr0_pc;
         if (if_mask == 2'b11) begin
            mem_inst[wr_ptr_nxt] <= if_inst1;
            mem_pc[wr_ptr_nxt]   <= pc_hi;
         end
      end
   end

endmodule

// File: tb/tb_inst_buf.sv
// tb_inst_buf: randomized and directed checks of inst_buf against a queue-based model.
// Latency: inputs applied at negedge, outputs compared at the following negedge.
// Backpressure: the model accepts a packet only when at least two entries are free.
module tb_inst_buf;
   localparam int DEPTH = 8;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        if_valid = 1'b0;
   logic        if_ready;
   logic [31:0] if_pc = '0;
   logic [1:0]  if_mask = '0;
   logic [31:0] if_inst0 = '0;
   logic [31:0] if_inst1 = '0;
   logic [1:0]  dec_valid;
   logic [31:0] dec_inst0, dec_inst1, dec_pc0, dec_pc1;
   logic [1:0]  dec_take = '0;

   int checks = 0;
   int errors = 0;

   inst_buf #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_mask(if_mask),
      .if_inst0(if_inst0), .if_inst1(if_inst1),
      .dec_valid(dec_valid), .dec_inst0(dec_inst0), .dec_inst1(dec_inst1),
      .dec_pc0(dec_pc0), .dec_pc1(dec_pc1), .dec_take(dec_take)
   );

   always #5 clk = ~clk;

   // Behavioural model: an ordered list of buffered instructions, oldest first.
   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } ent_t;
   ent_t q[$];

   function automatic logic m_rdy();
      return (DEPTH - q.size()) >= 2;
   endfunction
   function automatic logic [1:0] m_vld();
      return {q.size() >= 2, q.size() >= 1};
   endfunction
   function automatic logic [31:0] m_inst(int s);
      return (q.size() > s) ? q[s].inst : NOP;
   endfunction
   function automatic logic [31:0] m_pc(int s);
      return (q.size() > s) ? q[s].pc : 32'h0;
   endfunction
   function automatic int m_avail();
      return (q.size() >= 2) ? 2 : q.size();
   endfunction

   // One clock of stimulus; starts and ends at a negedge and advances the model.
   task automatic drive(input logic v, input logic [31:0] pc, input logic [1:0] mask,
                        input logic [31:0] i0, input logic [31:0] i1,
                        input logic [1:0] take, input logic fl);
      bit acc;
      int n;
      ent_t e;
      if_valid = v; if_pc = pc; if_mask = mask; if_inst0 = i0; if_inst1 = i1;
      dec_take = take; flush = fl;
      acc = v && m_rdy() && !fl;
      checks++;
      if (int'(take) > int'(dec_valid[0]) + int'(dec_valid[1])) begin
         errors++;
         $display("FAIL take_exceeds_valid: dec_take=%0d dec_valid=%b", take, dec_valid);
      end
      @(posedge clk);
      if (fl) begin
         q.delete();
      end else begin
         n = (int'(take) < m_avail()) ? int'(take) : m_avail();
         repeat (n) void'(q.pop_front());
         if (acc) begin
            if (mask[0]) begin e.inst = i0; e.pc = pc;      q.push_back(e); end
            if (mask[1]) begin e.inst = i1; e.pc = pc + 4; q.push_back(e); end
         end
      end
      @(negedge clk);
      if_valid = 1'b0; if_mask = 2'b00; dec_take = 2'd0; flush = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      if_valid = 1'b1; if_pc = 32'h80; if_mask = 2'b11; if_inst0 = 32'hAAAA; if_inst1 = 32'hBBBB;
      @(posedge clk);
      @(negedge clk);
      checks++; if (dec_valid !== 2'b00) begin errors++; $display("FAIL rst_valid got=%b exp=00", dec_valid); end
      checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", if_ready); end
      checks++; if (dec_inst0 !== NOP) begin errors++; $display("FAIL rst_inst0 got=%h exp=%h", dec_inst0, NOP); end
      checks++; if (dec_inst1 !== NOP) begin errors++; $display("FAIL rst_inst1 got=%h exp=%h", dec_inst1, NOP); end
      checks++; if (dec_pc0 !== 32'h0 || dec_pc1 !== 32'h0) begin
         errors++; $display("FAIL rst_pc got=%h/%h exp=0/0", dec_pc0, dec_pc1);
      end
      rst = 1'b0;
      if_valid = 1'b0; if_mask = 2'b00;
      q.delete();
   endtask

   task automatic test_basic();
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      drive(1'b1, 32'h100, 2'b11, a, b, 2'd0, 1'b0);
      checks++; if (dec_valid !== 2'b11) begin errors++; $display("FAIL basic_valid got=%b exp=11", dec_valid); end
      checks++; if (dec_pc0 !== 32'h100) begin errors++; $display("FAIL basic_pc0 got=%h exp=100", dec_pc0); end
      checks++; if (dec_pc1 !== 32'h104) begin errors++; $display("FAIL basic_pc1 got=%h exp=104", dec_pc1); end
      checks++; if (dec_inst0 !== a) begin errors++; $display("FAIL basic_inst0 got=%h exp=%h", dec_inst0, a); end
      checks++; if (dec_inst1 !== b) begin errors++; $display("FAIL basic_inst1 got=%h exp=%h", dec_inst1, b); end
      a = $urandom; b = $urandom;
      drive(1'b1, 32'h208, 2'b10, a, b, 2'd2, 1'b0);
      checks++; if (dec_valid !== 2'b01) begin errors++; $display("FAIL hole_valid got=%b exp=01", dec_valid); end
      checks++; if (dec_inst0 !== b) begin errors++; $display("FAIL hole_inst0 got=%h exp=%h", dec_inst0, b); end
      checks++; if (dec_pc0 !== 32'h20C) begin errors++; $display("FAIL hole_pc0 got=%h exp=20c", dec_pc0); end
      checks++; if (dec_inst1 !== NOP || dec_pc1 !== 32'h0) begin
         errors++; $display("FAIL hole_slot1 got=%h/%h exp=%h/0", dec_inst1, dec_pc1, NOP);
      end
      drive(1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 2'd1, 1'b0);
      checks++; if (dec_valid !== 2'b00) begin errors++; $display("FAIL basic_empty got=%b exp=00", dec_valid); end
   endtask

   task automatic test_full();
      drive(1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 2'd0, 1'b1);
      for (int k = 0; k < 3; k++) drive(1'b1, 32'h1000 + 32'(k * 8), 2'b11, $urandom, $urandom, 2'd0, 1'b0);
      checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL full6_ready got=%b exp=1", if_ready); end
      drive(1'b1, 32'h1018, 2'b11, $urandom, $urandom, 2'd0, 1'b0);
      checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL full8_ready got=%b exp=0", if_ready); end
      drive(1'b1, 32'h1020, 2'b11, $urandom, $urandom, 2'd0, 1'b0);
      checks++; if (dec_pc0 !== 32'h1000 || if_ready !== 1'b0) begin
         errors++; $display("FAIL full_hold got pc0=%h rdy=%b exp pc0=1000 rdy=0", dec_pc0, if_ready);
      end
      drive(1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 2'd1, 1'b0);
      checks++; if (if_ready !== 1'b0 || dec_pc0 !== 32'h1004) begin
         errors++; $display("FAIL full7 got rdy=%b pc0=%h exp rdy=0 pc0=1004", if_ready, dec_pc0);
      end
      drive(1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 2'd1, 1'b0);
      checks++; if (if_ready !== 1'b1 || dec_pc0 !== 32'h1008) begin
         errors++; $display("FAIL full6b got rdy=%b pc0=%h exp rdy=1 pc0=1008", if_ready, dec_pc0);
      end
      for (int k = 0; k < 4 && q.size() > 0; k++) begin
         drive(1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 2'(m_avail()), 1'b0);
         checks++; if (dec_pc0 !== m_pc(0) || dec_inst0 !== m_inst(0) || dec_valid !== m_vld()) begin
            errors++; $display("FAIL full_drain got pc0=%h inst0=%h vld=%b exp %h %h %b",
                               dec_pc0, dec_inst0, dec_valid, m_pc(0), m_inst(0), m_vld());
         end
      end
   endtask

   task automatic test_simul();
      drive(1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 2'd0, 1'b1);
      drive(1'b1, 32'h2000, 2'b11, $urandom, $urandom, 2'd0, 1'b0);
      drive(1'b1, 32'h2008, 2'b01, $urandom, $urandom, 2'd0, 1'b0);
      drive(1'b1, 32'h2010, 2'b11, $urandom, $urandom, 2'd1, 1'b0);
      checks++; if (dec_pc0 !== 32'h2004 || dec_pc1 !== 32'h2008) begin
         errors++; $display("FAIL simul_slots got=%h/%h exp=2004/2008", dec_pc0, dec_pc1);
      end
      checks++; if (dec_valid !== 2'b11 || if_ready !== 1'b1) begin
         errors++; $display("FAIL simul_state got vld=%b rdy=%b exp 11/1", dec_valid, if_ready);
      end
      drive(1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
      checks++; if (dec_pc0 !== 32'h2010 || dec_pc1 !== 32'h2014) begin
         errors++; $display("FAIL simul_next got=%h/%h exp=2010/2014", dec_pc0, dec_pc1);
      end
      drive(1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
      checks++; if (dec_valid !== 2'b00) begin errors++; $display("FAIL simul_count4 got=%b exp=00", dec_valid); end
   endtask

   task automatic test_flush();
      drive(1'b1, 32'h3000, 2'b11, $urandom, $urandom, 2'd0, 1'b0);
      drive(1'b1, 32'h3008, 2'b11, $urandom, $urandom, 2'd0, 1'b0);
      drive(1'b1, 32'h3010, 2'b01, $urandom, $urandom, 2'd0, 1'b0);
      checks++; if (dec_valid !== 2'b11) begin errors++; $display("FAIL flush_pre got=%b exp=11", dec_valid); end
      drive(1'b1, 32'h3018, 2'b11, $urandom, $urandom, 2'd2, 1'b1);
      checks++; if (dec_valid !== 2'b00 || if_ready !== 1'b1) begin
         errors++; $display("FAIL flush_state got vld=%b rdy=%b exp 00/1", dec_valid, if_ready);
      end
      checks++; if (dec_inst0 !== NOP) begin errors++; $display("FAIL flush_nop got=%h exp=%h", dec_inst0, NOP); end
      drive(1'b1, 32'h400, 2'b11, $urandom, $urandom, 2'd0, 1'b0);
      checks++; if (dec_pc0 !== 32'h400 || dec_pc1 !== 32'h404 || dec_valid !== 2'b11) begin
         errors++; $display("FAIL flush_after got pc=%h/%h vld=%b exp 400/404/11", dec_pc0, dec_pc1, dec_valid);
      end
      drive(1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 2'd0, 1'b1);
   endtask

   task automatic test_back_to_back();
      int sent = 0;
      logic [31:0] exp_pc = 32'h0;
      int n;
      bit acc;
      drive(1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 2'd0, 1'b1);
      for (int cyc = 0; cyc < 100 && (sent < 20 || q.size() > 0); cyc++) begin
         n = m_avail();
         if (n >= 1) begin
            checks++; if (dec_pc0 !== exp_pc || dec_inst0 !== m_inst(0)) begin
               errors++; $display("FAIL wrap_slot0 got pc=%h inst=%h exp pc=%h inst=%h", dec_pc0, dec_inst0, exp_pc, m_inst(0));
            end
            exp_pc = exp_pc + 4;
         end
         if (n >= 2) begin
            checks++; if (dec_pc1 !== exp_pc || dec_inst1 !== m_inst(1)) begin
               errors++; $display("FAIL wrap_slot1 got pc=%h inst=%h exp pc=%h inst=%h", dec_pc1, dec_inst1, exp_pc, m_inst(1));
            end
            exp_pc = exp_pc + 4;
         end
         acc = (sent < 20) && m_rdy();
         drive(sent < 20, 32'(sent * 8), 2'b11, $urandom, $urandom, 2'(n), 1'b0);
         if (acc) sent++;
      end
      checks++; if (exp_pc !== 32'd160 || dec_valid !== 2'b00) begin
         errors++; $display("FAIL wrap_total got pc=%h vld=%b exp pc=a0 vld=00", exp_pc, dec_valid);
      end
   endtask

   task automatic test_random();
      logic [1:0] take;
      for (int cyc = 0; cyc < 400; cyc++) begin
         take = 2'($urandom_range(0, m_avail()));
         drive($urandom_range(0, 3) != 0, {$urandom, 3'b000}, 2'($urandom), $urandom, $urandom, take,
               $urandom_range(0, 24) == 0);
         checks++; if (dec_valid !== m_vld()) begin errors++; $display("FAIL rnd_valid got=%b exp=%b", dec_valid, m_vld()); end
         checks++; if (if_ready !== m_rdy()) begin errors++; $display("FAIL rnd_ready got=%b exp=%b", if_ready, m_rdy()); end
         checks++; if (dec_inst0 !== m_inst(0) || dec_pc0 !== m_pc(0)) begin
            errors++; $display("FAIL rnd_slot0 got=%h/%h exp=%h/%h", dec_inst0, dec_pc0, m_inst(0), m_pc(0));
         end
         checks++; if (dec_inst1 !== m_inst(1) || dec_pc1 !== m_pc(1)) begin
            errors++; $display("FAIL rnd_slot1 got=%h/%h exp=%h/%h", dec_inst1, dec_pc1, m_inst(1), m_pc(1));
         end
      end
   endtask

   task automatic test_async_reset();
      drive(1'b1, 32'h500, 2'b11, $urandom, $urandom, 2'd0, 1'b0);
      #2 rst = 1'b1;
      #1;
      checks++; if (dec_valid !== 2'b00 || if_ready !== 1'b1 || dec_pc0 !== 32'h0) begin
         errors++; $display("FAIL async_rst got vld=%b rdy=%b pc0=%h exp 00/1/0", dec_valid, if_ready, dec_pc0);
      end
      @(negedge clk);
      rst = 1'b0;
      q.delete();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_simul();
      test_flush();
      test_back_to_back();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
